// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared state encoding and truth-table constants for the gate self-test
package gate_check_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam int SETTLE_W = 4;
endpackage

// File: rtl/gate_check_sequencer.sv
// gate_check_sequencer: walks {a,b} through 00..11, samples y after SETTLE cycles, reports mismatches
module gate_check_sequencer
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_NAND,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);
  state_t state, state_n;
  logic [SETTLE_W-1:0] count;
  logic last;
  logic [3:0] mask_n;
  assign last = count == SETTLE_W'(SETTLE - 1);
  assign a = vec_idx[1];
  assign b = vec_idx[0];
  assign busy = state == DRIVE;
  assign done = state == DONE;
  always_comb begin
    mask_n = fail_mask;
    mask_n[vec_idx] = y != TRUTH[vec_idx];
    state_n = state == IDLE  ? (start ? DRIVE : IDLE) :
              state == DRIVE ? ((last && vec_idx == 2'd3) ? DONE : DRIVE) : IDLE;
  end
  // pass is resolved on the DONE entry edge so it already includes the final vector's bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      vec_idx <= '0;
      count <= '0;
      fail_mask <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        vec_idx <= '0;
        count <= '0;
        fail_mask <= '0;
        pass <= 1'b0;
      end else if (state == DRIVE) begin
        if (!last) count <= count + 1'b1;
        else begin
          fail_mask <= mask_n;
          count <= '0;
          if (vec_idx == 2'd3) pass <= ~|mask_n;
          else vec_idx <= vec_idx + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_check_sequencer.sv
// tb_gate_check_sequencer: directed runs against a timeline model of the gate self-test
module tb_gate_check_sequencer;
  import gate_check_pkg::*;
  localparam int S = 2;
  logic clk = 0, rst, start, y;
  logic a, b, busy, done, pass;
  logic [1:0] vec_idx, mode;
  logic [3:0] fail_mask;
  int checks = 0, failures = 0, cyc = 0;
  gate_check_sequencer #(.TRUTH(TT_NAND), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .a(a), .b(b), .vec_idx(vec_idx),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic gate(input logic [1:0] md, input logic ga, input logic gb);
    return md == 2'd0 ? ~(ga & gb) : md == 2'd1 ? 1'b0 : (ga & gb);
  endfunction
  always_comb y = gate(mode, a, b);
  function automatic logic [3:0] mism_of(input logic [1:0] md);
    logic [3:0] r;
    logic [3:0] tt;
    tt = TT_NAND;
    for (int i = 0; i < 4; i++) r[i] = gate(md, i[1], i[0]) != tt[i];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask
  // model: a run is a timeline of offsets from the accepting edge
  logic m_run = 0;
  int m_t = 0;
  logic [3:0] m_mism = 0, h_mask = 0;
  logic [1:0] h_vec = 0;
  logic h_pass = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_t <= 0; m_mism <= 0; h_vec <= 0; h_mask <= 0; h_pass <= 0;
    end else if (!m_run) begin
      if (start) begin m_run <= 1; m_t <= 0; m_mism <= mism_of(mode); end
    end else begin
      m_t <= m_t + 1;
      if (m_t == 4 * S) begin
        m_run <= 0; h_vec <= 2'd3; h_mask <= m_mism; h_pass <= m_mism == 0;
      end
    end
  end
  always @(negedge clk) begin
    logic e_busy, e_done, e_pass;
    logic [1:0] e_vec;
    logic [3:0] e_mask;
    if (!rst) begin
      e_busy = m_run && m_t < 4 * S;
      e_done = m_run && m_t == 4 * S;
      if (e_busy) begin
        e_vec = 2'(m_t / S);
        for (int i = 0; i < 4; i++) e_mask[i] = (i + 1) * S <= m_t ? m_mism[i] : 1'b0;
        e_pass = 0;
      end else if (e_done) begin
        e_vec = 2'd3; e_mask = m_mism; e_pass = m_mism == 0;
      end else begin
        e_vec = h_vec; e_mask = h_mask; e_pass = h_pass;
      end
      chk("busy", 16'(busy), 16'(e_busy));
      chk("done", 16'(done), 16'(e_done));
      chk("vec_idx", 16'(vec_idx), 16'(e_vec));
      chk("ab", 16'({a, b}), 16'(e_vec));
      chk("fail_mask", 16'(fail_mask), 16'(e_mask));
      chk("pass", 16'(pass), 16'(e_pass));
    end
  end
  task automatic run(input logic [1:0] md, input int pulse, input logic [3:0] xm, input logic xp, input string nm);
    int n, e0;
    @(negedge clk); mode = md; start = 1;
    @(negedge clk); start = 0; e0 = cyc;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk); n++;
      start = pulse >= 0 && cyc - e0 == pulse;
    end
    start = 0;
    chk({nm, "_latency"}, 16'(cyc - e0), 16'(4 * S));
    chk({nm, "_mask"}, 16'(fail_mask), 16'(xm));
    chk({nm, "_pass"}, 16'(pass), 16'(xp));
    @(negedge clk);
  endtask
  initial begin
    int n, e0;
    rst = 1; start = 0; mode = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", 16'({a, b, vec_idx, busy, done, pass, fail_mask}), 16'h0);
    rst = 0;
    run(2'd0, -1, 4'b0000, 1'b1, "nand_ok");
    run(2'd1, -1, 4'b0111, 1'b0, "y_zero");
    run(2'd2, -1, 4'b1111, 1'b0, "and_gate");
    run(2'd0, 3, 4'b0000, 1'b1, "start_busy");
    // start held: second run begins two edges after DONE entry
    @(negedge clk); mode = 2'd1; start = 1;
    @(negedge clk); e0 = cyc;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    chk("hold_restart", 16'(cyc - e0), 16'(4 * S + 2));
    chk("hold_mask_clr", 16'(fail_mask), 16'h0);
    chk("hold_pass_clr", 16'(pass), 16'h0);
    start = 0;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("hold_second_mask", 16'(fail_mask), 16'(4'b0111));
    @(negedge clk);
    // asynchronous reset mid-run
    mode = 2'd0; start = 1;
    @(negedge clk); start = 0; e0 = cyc;
    n = 0;
    while (cyc - e0 < 5 && n < 20) begin @(negedge clk); n++; end
    #2 rst = 1;
    #1 chk("async_rst", 16'({a, b, vec_idx, busy, done, pass, fail_mask}), 16'h0);
    @(negedge clk); rst = 0;
    run(2'd0, -1, 4'b0000, 1'b1, "post_rst");
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
